// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encodings and frame constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_pkg;

    // Receiver FSM encodings, kept 3 bits wide to sit alongside the transmitter's states.
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Frame format: 8 data bits, even parity.
    localparam int DATA_BITS   = 8;
    localparam bit PARITY_EVEN = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer: SYNC_STAGES flop chain, reset to 1 (line idle level).
// Latency: SYNC_STAGES cycles from async_in to sync_out.
// Backpressure: none; free-running every cycle.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw input one stage further down the chain each cycle.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    // Chain registers; reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, 1 stop; mid-bit sampling.
// Latency: SYNC_STAGES + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT cycles from start edge to strobe (+-1).
// Backpressure: none; strobes are single-cycle and must be taken when issued.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e              state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   perr_q, perr_d;
    logic                   armed_q, armed_d;
    logic                   valid_q, valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx),
        .sync_out (rx_s)
    );

    // Next-state, bit timing, sampling and strobe generation.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        perr_d       = perr_q;
        armed_d      = armed_q;
        valid_d      = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                tick_d = '0;
                idx_d  = '0;
                // A break leaves the line low; wait for it to go high before re-arming.
                if (rx_s) begin
                    armed_d = 1'b1;
                end
                if (en && !rx_s && armed_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick_q == HALF_LAST) begin
                    tick_d = '0;
                    // Still low at mid-start: real start bit; otherwise a glitch.
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            RX_DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_d          = '0;
                    shift_d[idx_q]  = rx_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = RX_PARITY;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            RX_PARITY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    perr_d  = rx_s ^ (^shift_q) ^ !PARITY_EVEN;
                    state_d = RX_STOP;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            RX_STOP: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    state_d = RX_IDLE;
                    if (!rx_s) begin
                        // Framing error wins over parity; also disarm until line recovers.
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
                    end else if (perr_q) begin
                        parity_err_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            tick_q       <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            perr_q       <= 1'b0;
            armed_q      <= 1'b1;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            perr_q       <= perr_d;
            armed_q      <= armed_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit, strobes counted per step.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_perr  = 0;
    int n_ferr  = 0;
    int n_viol  = 0;
    int last_valid_cyc = 0;
    logic [7:0] vdat [0:7];
    logic prev_strobe = 1'b0;
    int t0;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        int k;
        k = int'(valid) + int'(parity_err) + int'(frame_err);
        if (k > 1) n_viol++;
        if (k > 0 && prev_strobe) n_viol++;
        prev_strobe = (k > 0);
        if (valid) begin
            if (n_valid < 8) vdat[n_valid] = data;
            n_valid++;
            last_valid_cyc = cyc;
        end
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        n_valid = 0;
        n_perr  = 0;
        n_ferr  = 0;
    endtask

    // One full frame: start, 8 data LSB first, parity, stop. rx is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
        logic [10:0] bits;
        bits = {stp, par, b, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            wait_cyc(CPB);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        rx  = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        clr_cnt();

        // Reset then idle.
        wait_cyc(100);
        @(negedge clk);
        check("idle_busy",  {31'd0, busy}, 32'd0);
        check("idle_data",  {24'd0, data}, 32'h00);
        check("idle_strb",  {29'd0, valid, parity_err, frame_err}, 32'd0);
        check("idle_cnt",   n_valid + n_perr + n_ferr, 32'd0);
        wait_cyc(1);

        // Good frame 0xA5, even parity 0.
        clr_cnt();
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_cyc(10);
        check("a5_valid", n_valid, 32'd1);
        check("a5_data",  {24'd0, data}, 32'hA5);
        check("a5_errs",  n_perr + n_ferr, 32'd0);
        check("a5_lat_in_window",
              {31'd0, ((last_valid_cyc - t0) >= 169) && ((last_valid_cyc - t0) <= 171)}, 32'd1);

        // Parity error: 0x01 needs parity 1, send 0.
        clr_cnt();
        send_frame(8'h01, 1'b0, 1'b1);
        wait_cyc(10);
        check("perr_cnt",   n_perr, 32'd1);
        check("perr_valid", n_valid, 32'd0);
        check("perr_data",  {24'd0, data}, 32'hA5);

        // Framing error 0x3C, correct parity 0, stop 0, line left low.
        clr_cnt();
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_cyc(200);
        @(negedge clk);
        check("ferr_cnt",  n_ferr, 32'd1);
        check("ferr_perr", n_perr, 32'd0);
        check("ferr_noarm_busy", {31'd0, busy}, 32'd0);
        check("ferr_data", {24'd0, data}, 32'hA5);
        wait_cyc(1);
        rx = 1'b1;
        wait_cyc(20);

        // Start glitch: low for 3 cycles only.
        clr_cnt();
        rx = 1'b0;
        wait_cyc(3);
        rx = 1'b1;
        wait_cyc(40);
        @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_strb", n_valid + n_perr + n_ferr, 32'd0);
        wait_cyc(1);
        send_frame(8'h7E, 1'b0, 1'b1);
        wait_cyc(10);
        check("7e_valid", n_valid, 32'd1);
        check("7e_data",  {24'd0, data}, 32'h7E);

        // Receiver disabled: frame ignored.
        clr_cnt();
        en = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_cyc(10);
        check("dis_valid", n_valid, 32'd0);
        check("dis_busy",  {31'd0, busy}, 32'd0);
        en = 1'b1;
        wait_cyc(10);

        // Back-to-back 0x00 and 0xFF, no idle gap.
        clr_cnt();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_cyc(10);
        check("b2b_valid", n_valid, 32'd2);
        check("b2b_d0",    {24'd0, vdat[0]}, 32'h00);
        check("b2b_d1",    {24'd0, vdat[1]}, 32'hFF);
        check("b2b_errs",  n_perr + n_ferr, 32'd0);

        // Reset in the middle of DATA of a third frame (0x55).
        clr_cnt();
        rx = 1'b0;           // start
        wait_cyc(CPB);
        rx = 1'b1;           // bit0
        wait_cyc(CPB);
        rx = 1'b0;           // bit1
        wait_cyc(CPB);
        rx = 1'b1;           // bit2
        wait_cyc(CPB);
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        wait_cyc(1);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {24'd0, data}, 32'h00);
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(200);
        check("rst_strb", n_valid + n_perr + n_ferr, 32'd0);
        check("strobe_excl", n_viol, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
